// File: rtl/camera_capture_fsm.sv
// rtl/camera_capture_fsm.sv - capture sequencer: erase, timed exposure, two-row readout
module camera_capture_fsm #(
  parameter int EXP_W   = 5,
  parameter int EXP_MIN = 2,
  parameter int EXP_MAX = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [EXP_W-1:0] ex_time,
  output logic             erase,
  output logic             expose,
  output logic             nre_1,
  output logic             nre_2,
  output logic             adc,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXPOSE  = 2'd1;
  localparam logic [1:0] READOUT = 2'd2;

  logic [1:0]       state, state_n;
  logic [EXP_W-1:0] cnt, cnt_n;
  logic [2:0]       row, row_n;
  logic [EXP_W-1:0] exp_n;
  logic             erase_n, expose_n, nre_1_n, nre_2_n, adc_n, busy_n, frame_done_n;

  // Readout row pattern as {nre_1, nre_2, adc, frame_done}
  function automatic logic [3:0] ro_out(input logic [2:0] r);
    case (r)
      3'd0:    ro_out = 4'b0100;
      3'd1:    ro_out = 4'b0110;
      3'd2:    ro_out = 4'b0100;
      3'd3:    ro_out = 4'b1100;
      3'd4:    ro_out = 4'b1000;
      3'd5:    ro_out = 4'b1010;
      3'd6:    ro_out = 4'b1000;
      default: ro_out = 4'b1101;
    endcase
  endfunction

  always_comb begin
    if (int'(ex_time) < EXP_MIN)
      exp_n = EXP_W'(EXP_MIN);
    else if (int'(ex_time) > EXP_MAX)
      exp_n = EXP_W'(EXP_MAX);
    else
      exp_n = ex_time;
  end

  // Next outputs are computed alongside the next state so every output is a flop
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    row_n        = row;
    erase_n      = 1'b1;
    expose_n     = 1'b0;
    nre_1_n      = 1'b1;
    nre_2_n      = 1'b1;
    adc_n        = 1'b0;
    busy_n       = 1'b0;
    frame_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (init) begin
          state_n  = EXPOSE;
          cnt_n    = exp_n;
          erase_n  = 1'b0;
          expose_n = 1'b1;
          busy_n   = 1'b1;
        end
      end
      EXPOSE: begin
        erase_n = 1'b0;
        busy_n  = 1'b1;
        if (cnt == EXP_W'(1)) begin
          state_n = READOUT;
          cnt_n   = '0;
          row_n   = 3'd0;
          {nre_1_n, nre_2_n, adc_n, frame_done_n} = ro_out(3'd0);
        end else begin
          cnt_n    = cnt - EXP_W'(1);
          expose_n = 1'b1;
        end
      end
      READOUT: begin
        if (row == 3'd7) begin
          state_n = IDLE;
          row_n   = 3'd0;
        end else begin
          row_n   = row + 3'd1;
          erase_n = 1'b0;
          busy_n  = 1'b1;
          {nre_1_n, nre_2_n, adc_n, frame_done_n} = ro_out(row + 3'd1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      row        <= '0;
      erase      <= 1'b1;
      expose     <= 1'b0;
      nre_1      <= 1'b1;
      nre_2      <= 1'b1;
      adc        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      row        <= row_n;
      erase      <= erase_n;
      expose     <= expose_n;
      nre_1      <= nre_1_n;
      nre_2      <= nre_2_n;
      adc        <= adc_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_camera_capture_fsm.sv
// tb/tb_camera_capture_fsm.sv - self-checking bench for camera_capture_fsm
module tb_camera_capture_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [4:0] ex_time = 5'd0;
  logic       erase, expose, nre_1, nre_2, adc, busy, frame_done;

  camera_capture_fsm #(.EXP_W(5), .EXP_MIN(2), .EXP_MAX(30)) dut (
    .clk(clk), .reset(reset), .init(init), .ex_time(ex_time),
    .erase(erase), .expose(expose), .nre_1(nre_1), .nre_2(nre_2),
    .adc(adc), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a capture is a timeline anchored at its init edge
  int edge_no  = 0;
  int m_start  = 0;
  int m_n      = 0;
  bit m_active = 1'b0;

  function automatic int clamp(input int x);
    return (x < 2) ? 2 : (x > 30) ? 30 : x;
  endfunction

  // {erase, expose, nre_1, nre_2, adc, busy, frame_done}
  function automatic logic [6:0] model_out();
    int t, r;
    t = edge_no - m_start + 1;
    if (!m_active || t > m_n + 8) return 7'b1011000;
    if (t <= m_n) return 7'b0111010;
    r = t - m_n - 1;
    return {1'b0, 1'b0, !(r <= 2), !(r >= 4 && r <= 6), (r == 1 || r == 5), 1'b1, (r == 7)};
  endfunction

  function automatic logic [6:0] dut_out();
    return {erase, expose, nre_1, nre_2, adc, busy, frame_done};
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, want, edge_no);
    end
  endtask

  task automatic step(input logic r, input logic i, input logic [4:0] x);
    @(negedge clk);
    reset = r; init = i; ex_time = x;
    @(posedge clk);
    edge_no++;
    if (r) m_active = 1'b0;
    else if (i && (!m_active || edge_no > m_start + m_n + 8)) begin
      m_active = 1'b1;
      m_start  = edge_no;
      m_n      = clamp(int'(x));
    end
    #1;
  endtask

  task automatic step_chk(input logic r, input logic i, input logic [4:0] x);
    step(r, i, x);
    check("model", int'(dut_out()), int'(model_out()));
  endtask

  typedef struct {
    logic       r;
    logic       i;
    logic [4:0] x;
    logic [6:0] e;
  } vec_t;
  vec_t tbl[$];

  // One capture with counters; mid_init pokes init while busy
  task automatic run_capture(input string name, input logic [4:0] x, input logic [4:0] x2,
                             input bit mid_init);
    int n, n_exp, n_adc, n_n1, n_n2, ovl, fd_off, er_off, adc1, adc2;
    n = clamp(int'(x));
    n_exp = 0; n_adc = 0; n_n1 = 0; n_n2 = 0; ovl = 0; fd_off = -1; er_off = -1; adc1 = -1; adc2 = -1;
    for (int t = 1; t <= 45; t++) begin
      if (t == 1) step_chk(1'b0, 1'b1, x);
      else step_chk(1'b0, mid_init && (t % 3 == 0), x2);
      if (expose) n_exp++;
      if (adc) begin
        n_adc++;
        if (adc1 < 0) adc1 = t; else adc2 = t;
      end
      if (!nre_1) n_n1++;
      if (!nre_2) n_n2++;
      if (!nre_1 && !nre_2) ovl++;
      if (frame_done) fd_off = t;
      if (erase && fd_off > 0) begin
        er_off = t;
        break;
      end
    end
    if (er_off < 0) $display("FAIL %s timeout: no return to idle within 45 cycles, expected 1", name);
    check({name, " expose_cycles"}, n_exp, n);
    check({name, " adc_pulses"}, n_adc, 2);
    check({name, " adc_offsets"}, adc1 * 100 + adc2, (n + 2) * 100 + (n + 6));
    check({name, " nre1_low"}, n_n1, 3);
    check({name, " nre2_low"}, n_n2, 3);
    check({name, " nre_overlap"}, ovl, 0);
    check({name, " frame_done_offset"}, fd_off, n + 8);
    check({name, " erase_offset"}, er_off, n + 9);
  endtask

  initial begin
    int last_fd, erase_between, frames;

    // Reset+init together, then a clamped ex_time=0 capture (N=2), hand-derived
    tbl.push_back('{1'b1, 1'b1, 5'd9, 7'b1011000});
    tbl.push_back('{1'b0, 1'b0, 5'd9, 7'b1011000});
    tbl.push_back('{1'b0, 1'b1, 5'd0, 7'b0111010});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0111010});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0001010});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0001110});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0001010});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0011010});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0010010});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0010110});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0010010});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b0011011});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b1011000});
    tbl.push_back('{1'b0, 1'b0, 5'd0, 7'b1011000});

    step(1'b1, 1'b0, 5'd0);
    check("reset_state", int'(dut_out()), 7'b1011000);
    foreach (tbl[j]) begin
      step(tbl[j].r, tbl[j].i, tbl[j].x);
      check($sformatf("table[%0d]", j), int'(dut_out()), int'(tbl[j].e));
    end

    run_capture("nominal", 5'd10, 5'd10, 1'b0);
    run_capture("clamp_hi", 5'd31, 5'd31, 1'b0);
    run_capture("clamp_one", 5'd1, 5'd1, 1'b0);
    run_capture("latch", 5'd5, 5'd20, 1'b1);

    // Reset for 3 cycles from the middle of EXPOSE
    step_chk(1'b0, 1'b1, 5'd20);
    for (int j = 0; j < 5; j++) step_chk(1'b0, 1'b0, 5'd20);
    step(1'b1, 1'b0, 5'd20);
    check("mid_expose_reset", int'(dut_out()), 7'b1011000);
    step_chk(1'b1, 1'b1, 5'd20);
    step_chk(1'b1, 1'b0, 5'd20);
    step_chk(1'b0, 1'b0, 5'd20);

    // Back-to-back with init held: period N+9 = 11, one erase cycle between frames
    last_fd = -1; erase_between = 0; frames = 0;
    for (int t = 1; t <= 50; t++) begin
      step_chk(1'b0, 1'b1, 5'd2);
      if (erase) erase_between++;
      if (frame_done) begin
        if (last_fd > 0) begin
          check("b2b_period", t - last_fd, 11);
          check("b2b_erase_gap", erase_between, 1);
        end
        last_fd = t; erase_between = 0; frames++;
      end
    end
    check("b2b_frames", frames, 4);
    step_chk(1'b1, 1'b0, 5'd2);

    // Randomized traffic against the timeline model
    for (int t = 0; t < 800; t++)
      step_chk($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
